// File: rtl/atm_session_if.sv
// Terminal-side bus for the ATM session controller: card/PIN entry,
// transaction requests and the controller's responses and status.
interface atm_session_if #(
   parameter int unsigned ID_W  = 4,
   parameter int unsigned PIN_W = 4,
   parameter int unsigned BAL_W = 18,
   parameter int unsigned AMT_W = 12
);
   logic             card_inserted;
   logic [ID_W-1:0]  card_id;
   logic             pin_valid;
   logic [PIN_W-1:0] pin;
   logic             req_valid;
   logic [1:0]       request;
   logic [AMT_W-1:0] amount;
   logic             ready;
   logic             resp_valid;
   logic             resp_ok;
   logic [BAL_W-1:0] balance_out;
   logic             card_eject;
   logic             locked_out;
   logic [2:0]       state_out;

   modport master (
      output card_inserted, card_id, pin_valid, pin, req_valid, request, amount,
      input  ready, resp_valid, resp_ok, balance_out, card_eject, locked_out, state_out
   );

   modport slave (
      input  card_inserted, card_id, pin_valid, pin, req_valid, request, amount,
      output ready, resp_valid, resp_ok, balance_out, card_eject, locked_out, state_out
   );
endinterface

// File: rtl/atm_session_ctrl.sv
// ATM session controller: card/PIN authentication, balance/deposit/withdraw
// against an internal account table. Define ATM_LOCKOUT_EN for PIN lockout.
module atm_session_ctrl #(
   parameter int unsigned NUM_ACCTS   = 8,
   parameter int unsigned ID_W        = 4,
   parameter int unsigned PIN_W       = 4,
   parameter int unsigned BAL_W       = 18,
   parameter int unsigned AMT_W       = 12,
   parameter int unsigned INIT_BAL    = 125000,
   parameter int unsigned DEP_LIMIT   = 2000,
   parameter int unsigned TIMEOUT_CYC = 1000,
   parameter int unsigned MAX_TRIES   = 3
) (
   input  logic          clk,
   input  logic          rst,
   atm_session_if.slave  bus
);
   localparam int unsigned IDX_W = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned SUM_W = BAL_W + 1;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      AUTH     = 3'd1,
      MENU     = 3'd2,
      BALANCE  = 3'd3,
      DEPOSIT  = 3'd4,
      WITHDRAW = 3'd5,
      EJECT    = 3'd6,
      LOCKED   = 3'd7
   } state_t;

   state_t           state, state_nxt;
   logic             card_prev;
   logic [TMO_W-1:0] idle_cnt;
   logic             timeout;
   logic [IDX_W-1:0] acct_idx, match_idx;
   logic             pin_match;
   logic [AMT_W-1:0] amt_q;
   logic [BAL_W-1:0] bal [NUM_ACCTS];
   logic [BAL_W-1:0] cur_bal, new_bal;
   logic [SUM_W-1:0] dep_sum;
   logic             op_state, op_ok;
   logic             resp_valid_q, resp_ok_q, eject_q;
   logic [BAL_W-1:0] bal_out_q;
   logic [NUM_ACCTS-1:0] lock_flag;

`ifdef ATM_LOCKOUT_EN
   localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
   logic [TRY_W-1:0] fail_cnt;
   logic             last_try, auth_fail, id_hit;
   logic [IDX_W-1:0] id_idx;

   assign last_try  = (fail_cnt == TRY_W'(MAX_TRIES - 1));
   assign auth_fail = (state == AUTH) && bus.card_inserted && bus.pin_valid && !pin_match;

   // The lock lands on whichever account owns the presented ID, regardless of PIN.
   always_comb begin
      id_hit = 1'b0;
      id_idx = '0;
      for (int i = 0; i < NUM_ACCTS; i++) begin
         if (bus.card_id == ID_W'(i + 1)) begin
            id_hit = 1'b1;
            id_idx = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fail_cnt  <= '0;
         lock_flag <= '0;
      end else begin
         if (state == IDLE)
            fail_cnt <= '0;
         else if (auth_fail)
            fail_cnt <= fail_cnt + 1'b1;
         if (state_nxt == LOCKED && id_hit)
            lock_flag[id_idx] <= 1'b1;
      end
   end
`else
   assign lock_flag = '0;
`endif

   always_comb begin
      pin_match = 1'b0;
      match_idx = '0;
      for (int i = 0; i < NUM_ACCTS; i++) begin
         if (bus.card_id == ID_W'(i + 1) && bus.pin == PIN_W'(i + 1) && !lock_flag[i]) begin
            pin_match = 1'b1;
            match_idx = IDX_W'(i);
         end
      end
   end

   assign timeout  = (idle_cnt == TMO_W'(TIMEOUT_CYC - 1));
   assign op_state = (state == BALANCE) || (state == DEPOSIT) || (state == WITHDRAW);

   // Deposit headroom is checked one bit wider so an overflowing sum is refused.
   always_comb begin
      cur_bal = bal[acct_idx];
      dep_sum = {1'b0, cur_bal} + SUM_W'(amt_q);
      new_bal = cur_bal;
      op_ok   = 1'b1;
      case (state)
         DEPOSIT: begin
            if (32'(amt_q) <= DEP_LIMIT && !dep_sum[BAL_W])
               new_bal = dep_sum[BAL_W-1:0];
            else
               op_ok = 1'b0;
         end
         WITHDRAW: begin
            if (BAL_W'(amt_q) <= cur_bal)
               new_bal = cur_bal - BAL_W'(amt_q);
            else
               op_ok = 1'b0;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.card_inserted && !card_prev) state_nxt = AUTH;
         AUTH: begin
            if (!bus.card_inserted)
               state_nxt = IDLE;
            else if (bus.pin_valid) begin
               if (pin_match)
                  state_nxt = MENU;
`ifdef ATM_LOCKOUT_EN
               else if (last_try)
                  state_nxt = LOCKED;
`endif
            end else if (timeout)
               state_nxt = EJECT;
         end
         MENU: begin
            if (!bus.card_inserted)
               state_nxt = IDLE;
            else if (bus.req_valid) begin
               case (bus.request)
                  2'b00:   state_nxt = BALANCE;
                  2'b01:   state_nxt = DEPOSIT;
                  2'b10:   state_nxt = WITHDRAW;
                  default: state_nxt = EJECT;
               endcase
            end else if (timeout)
               state_nxt = EJECT;
         end
         BALANCE, DEPOSIT, WITHDRAW: state_nxt = MENU;
         EJECT:   if (!bus.card_inserted) state_nxt = IDLE;
         LOCKED:  state_nxt = EJECT;
         default: state_nxt = IDLE;
      endcase
   end

   // Inactivity only accumulates while parked in AUTH/MENU; any transition or PIN entry clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         card_prev    <= 1'b0;
         idle_cnt     <= '0;
         acct_idx     <= '0;
         amt_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_ok_q    <= 1'b0;
         bal_out_q    <= '0;
         eject_q      <= 1'b0;
         for (int i = 0; i < NUM_ACCTS; i++)
            bal[i] <= BAL_W'(INIT_BAL);
      end else begin
         state     <= state_nxt;
         card_prev <= bus.card_inserted;
         if ((state == AUTH || state == MENU) && state_nxt == state &&
             !(state == AUTH && bus.pin_valid))
            idle_cnt <= idle_cnt + 1'b1;
         else
            idle_cnt <= '0;
         if (state == AUTH && state_nxt == MENU)
            acct_idx <= match_idx;
         if (state == MENU && bus.req_valid)
            amt_q <= bus.amount;
         resp_valid_q <= op_state;
         resp_ok_q    <= op_state && op_ok;
         if (op_state) begin
            bal[acct_idx] <= new_bal;
            bal_out_q     <= new_bal;
         end
         eject_q <= (state_nxt == EJECT) && (state != EJECT);
      end
   end

   assign bus.ready       = (state == MENU);
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_ok     = resp_ok_q;
   assign bus.balance_out = bal_out_q;
   assign bus.card_eject  = eject_q;
   assign bus.state_out   = state;
`ifdef ATM_LOCKOUT_EN
   assign bus.locked_out  = (state == LOCKED);
`else
   assign bus.locked_out  = 1'b0;
`endif
endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl: a scoreboard queue holds the expected
// response of every transaction, popped when the DUT pulses resp_valid.
module tb_atm_session_ctrl;
   localparam int BAL_MAX = 262143;
   localparam int DEP_MAX = 2000;

   typedef struct {
      logic        ok;
      logic [31:0] bal;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   exp_t sb [$];
   int   model_bal [1:8];
   int   total = 0;
   int   bad = 0;

   atm_session_if #(.ID_W(4), .PIN_W(4), .BAL_W(18), .AMT_W(18)) bus ();

   atm_session_ctrl #(.AMT_W(18)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic insert_card();
      bus.card_inserted = 1'b1;
      tick();
      check_output("insert_auth", bus.state_out, 1);
   endtask

   task automatic remove_card();
      bus.card_inserted = 1'b0;
      tick();
      check_output("remove_idle", bus.state_out, 0);
   endtask

   task automatic enter_pin(input int id, input int pin_val, input int exp_state);
      bus.card_id   = 4'(id);
      bus.pin       = 4'(pin_val);
      bus.pin_valid = 1'b1;
      tick();
      bus.pin_valid = 1'b0;
      check_output("pin_state", bus.state_out, exp_state);
   endtask

   // One transaction: predict, push, drive, then wait (bounded) for the response.
   task automatic apply_stimulus(input int acct, input logic [1:0] op, input int amt, input bit drop_card);
      exp_t e;
      exp_t got;
      int   n;
      e.ok = 1'b1;
      case (op)
         2'b01: if (amt <= DEP_MAX && model_bal[acct] + amt <= BAL_MAX) model_bal[acct] += amt; else e.ok = 1'b0;
         2'b10: if (amt <= model_bal[acct]) model_bal[acct] -= amt; else e.ok = 1'b0;
         default: ;
      endcase
      e.bal = model_bal[acct];
      sb.push_back(e);
      check_output("ready", bus.ready, 1);
      bus.request   = op;
      bus.amount    = 18'(amt);
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      if (drop_card) bus.card_inserted = 1'b0;
      n = 1;
      while (!bus.resp_valid && n < 6) begin
         tick();
         n++;
      end
      check_output("resp_latency", n, 2);
      check_output("sb_nonempty", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
         got = sb.pop_front();
         check_output("resp_ok", bus.resp_ok, got.ok);
         check_output("balance_out", bus.balance_out, got.bal);
      end
      tick();
      check_output("resp_pulse", bus.resp_valid, 0);
   endtask

   task automatic end_session();
      check_output("ready_end", bus.ready, 1);
      bus.request   = 2'b11;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      check_output("end_eject_state", bus.state_out, 6);
      check_output("end_eject_pulse", bus.card_eject, 1);
      tick();
      check_output("eject_pulse_clear", bus.card_eject, 0);
      remove_card();
   endtask

   initial begin
      int n;
      bus.card_inserted = 1'b0;
      bus.card_id       = '0;
      bus.pin_valid     = 1'b0;
      bus.pin           = '0;
      bus.req_valid     = 1'b0;
      bus.request       = '0;
      bus.amount        = '0;
      for (int i = 1; i <= 8; i++) model_bal[i] = 125000;

      repeat (3) @(posedge clk);
      #1;
      check_output("rst_state", bus.state_out, 0);
      check_output("rst_ready", bus.ready, 0);
      check_output("rst_resp_valid", bus.resp_valid, 0);
      check_output("rst_resp_ok", bus.resp_ok, 0);
      check_output("rst_balance", bus.balance_out, 0);
      check_output("rst_eject", bus.card_eject, 0);
      check_output("rst_locked", bus.locked_out, 0);
      rst = 1'b1;
      tick();

      // Card 3: ignored request in AUTH, wrong PIN, ignored PIN in MENU, balance query
      insert_card();
      bus.request   = 2'b00;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      check_output("req_in_auth", bus.state_out, 1);
      tick();
      check_output("no_resp_in_auth", bus.resp_valid, 0);
      enter_pin(3, 5, 1);
      enter_pin(3, 3, 2);
      enter_pin(3, 3, 2);
      apply_stimulus(3, 2'b00, 0, 1'b0);
      end_session();

      // Card 1: deposit limit
      insert_card();
      enter_pin(1, 1, 2);
      apply_stimulus(1, 2'b01, 2000, 1'b0);
      apply_stimulus(1, 2'b01, 2001, 1'b0);
      apply_stimulus(1, 2'b00, 0, 1'b0);
      remove_card();

      // Card 2: withdraw to zero, then underflow attempt
      insert_card();
      enter_pin(2, 2, 2);
      apply_stimulus(2, 2'b10, 125000, 1'b0);
      apply_stimulus(2, 2'b10, 1, 1'b0);
      end_session();

      // Card 5: fill to the balance ceiling, then one more
      insert_card();
      enter_pin(5, 5, 2);
      repeat (68) apply_stimulus(5, 2'b01, 2000, 1'b0);
      apply_stimulus(5, 2'b01, 1143, 1'b0);
      apply_stimulus(5, 2'b01, 1, 1'b0);
      remove_card();

      // Card 6: card pulled while the deposit is in flight still commits
      insert_card();
      enter_pin(6, 6, 2);
      apply_stimulus(6, 2'b01, 100, 1'b1);
      check_output("pulled_idle", bus.state_out, 0);
      insert_card();
      enter_pin(6, 6, 2);
      apply_stimulus(6, 2'b00, 0, 1'b0);
      remove_card();

      // Removal during AUTH
      insert_card();
      remove_card();

      // Card 7: inactivity timeout in MENU
      insert_card();
      enter_pin(7, 7, 2);
      n = 0;
      while (bus.state_out == 3'd2 && n < 1100) begin
         n++;
         tick();
      end
      check_output("timeout_cycles", n, 1000);
      check_output("timeout_state", bus.state_out, 6);
      check_output("timeout_eject", bus.card_eject, 1);
      tick();
      check_output("timeout_eject_clear", bus.card_eject, 0);
      check_output("eject_hold", bus.state_out, 6);
      remove_card();

`ifdef ATM_LOCKOUT_EN
      insert_card();
      enter_pin(4, 5, 1);
      enter_pin(4, 5, 1);
      enter_pin(4, 5, 7);
      check_output("locked_out", bus.locked_out, 1);
      tick();
      check_output("lock_eject_state", bus.state_out, 6);
      check_output("lock_eject_pulse", bus.card_eject, 1);
      check_output("locked_clear", bus.locked_out, 0);
      remove_card();
      insert_card();
      enter_pin(4, 4, 1);
      remove_card();
      insert_card();
      enter_pin(3, 3, 2);
      remove_card();
`else
      insert_card();
      enter_pin(4, 5, 1);
      enter_pin(4, 5, 1);
      enter_pin(4, 5, 1);
      check_output("no_lock", bus.locked_out, 0);
      enter_pin(4, 4, 2);
      remove_card();
`endif

      // Reset mid-session restores every balance
      insert_card();
      enter_pin(1, 1, 2);
      rst = 1'b0;
      #1;
      check_output("async_rst_state", bus.state_out, 0);
      check_output("async_rst_balance", bus.balance_out, 0);
      bus.card_inserted = 1'b0;
      tick();
      rst = 1'b1;
      for (int i = 1; i <= 8; i++) model_bal[i] = 125000;
      tick();
      insert_card();
      enter_pin(1, 1, 2);
      apply_stimulus(1, 2'b00, 0, 1'b0);
      remove_card();
      insert_card();
      enter_pin(2, 2, 2);
      apply_stimulus(2, 2'b00, 0, 1'b0);
      remove_card();

      check_output("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/atm_session_ctrl.md
ATM_SESSION_CTRL -- requirements
Module: atm_session_ctrl

Interface
REQ-001 Parameter NUM_ACCTS, default 8, number of accounts in internal table.
REQ-002 Parameter ID_W, default 4, card-ID width.
REQ-003 Parameter PIN_W, default 4, PIN width.
REQ-004 Parameter BAL_W, default 18, balance width.
REQ-005 Parameter AMT_W, default 12, transaction amount width.
REQ-006 Parameter INIT_BAL, default 125000, reset balance of every account.
REQ-007 Parameter DEP_LIMIT, default 2000, maximum single deposit.
REQ-008 Parameter TIMEOUT_CYC, default 1000, inactivity cycles before forced eject.
REQ-009 Parameter MAX_TRIES, default 3, PIN failures before lockout.
REQ-010 clk  in  1  single clock; all state changes on rising edge.
REQ-011 rst  in  1  reset, asynchronous, active-low.
REQ-012 card_inserted  in  1  level, card present.
REQ-013 card_id  in  ID_W  card number, sampled with pin_valid.
REQ-014 pin_valid / pin  in  1 / PIN_W  one-cycle PIN entry strobe and value.
REQ-015 req_valid / request  in  1 / 2  op request: 00 balance, 01 deposit, 10 withdraw, 11 end session.
REQ-016 amount  in  AMT_W  deposit/withdraw amount, sampled with req_valid.
REQ-017 ready  out  1  high only in MENU; request accepted on req_valid && ready.
REQ-018 resp_valid / resp_ok  out  1 / 1  one-cycle response pulse and success flag.
REQ-019 balance_out  out  BAL_W  selected account balance, updated with every resp_valid.
REQ-020 card_eject  out  1  one-cycle pulse on entering EJECT.
REQ-021 locked_out  out  1  high while in LOCKED.
REQ-022 state_out  out  3  current state encoding.

Function
REQ-023 States: IDLE=0, AUTH=1, MENU=2, BALANCE=3, DEPOSIT=4, WITHDRAW=5, EJECT=6, LOCKED=7.
REQ-024 IDLE -> AUTH on card_inserted rising edge (low-to-high only).
REQ-025 AUTH: on pin_valid, match if card_id equals i+1 and pin equals (i+1) mod 2^PIN_W for some account i not lock-flagged; match -> MENU with index latched, else stay AUTH.
REQ-026 MENU: accepted request 00/01/10 -> matching op state; 11 -> EJECT.
REQ-027 Op states last exactly one cycle, commit, then return to MENU; resp_valid asserts the cycle after the op state (request-to-response latency 2 cycles).
REQ-028 Deposit succeeds iff amount <= DEP_LIMIT and balance+amount <= 2^BAL_W-1; no wrap-around.
REQ-029 Withdraw succeeds iff amount <= balance (equality allowed); balance never underflows.
REQ-030 Failed op leaves balance unchanged, resp_ok=0; balance request always resp_ok=1.
REQ-031 Inactivity counter clears on entry to AUTH/MENU and on pin_valid or accepted request; reaching TIMEOUT_CYC in AUTH or MENU -> EJECT.
REQ-032 card_inserted low in AUTH or MENU -> IDLE next cycle, no transaction; an op state already entered still commits.
REQ-033 EJECT -> IDLE when card_inserted low; remains EJECT otherwise.
REQ-034 req_valid outside MENU and pin_valid outside AUTH are ignored.

Reset
REQ-035 On rst low: state IDLE, all balances INIT_BAL, lock flags clear, counters zero, all outputs zero.

Configuration
REQ-036 Macro ATM_LOCKOUT_EN defined: AUTH failures counted per session; MAX_TRIES-th failure sets the lock flag of the account whose ID matches card_id (if any) and enters LOCKED for one cycle, then EJECT; flags clear only on reset.
REQ-037 ATM_LOCKOUT_EN undefined: unlimited retries, LOCKED unreachable, locked_out tied 0, no lock-flag storage.

Verification
REQ-038 Reset, insert, card_id=3 pin=3, request 00 -> resp_valid 2 cycles later, resp_ok=1, balance_out=125000.
REQ-039 Card 1: deposit 2000 -> ok, 127000; deposit 2001 -> resp_ok=0, 127000.
REQ-040 Card 2: withdraw 125000 -> ok, balance 0; withdraw 1 -> resp_ok=0, balance 0.
REQ-041 Enter MENU, no activity 1000 cycles -> card_eject pulse, state EJECT; remove card -> IDLE.
REQ-042 With ATM_LOCKOUT_EN: card 4 wrong pin x3 -> locked_out, eject; re-insert, correct pin 4 -> stays AUTH.
REQ-043 Card removed in MENU, rst asserted mid-session -> IDLE, balances back to 125000.
